frame_fetcher: RTL and testbench

Scanout-side reader for the SDRAM framebuffer: fetches one scanline of 32-bit pixels from SDRAM into a two-bank on-chip line buffer and serves 24-bit RGB to the video output by pixel coordinate. It sits between the SDRAM controller's user port and the video timing generator. Fetching line y+1 overlaps display of line y. The frame base latches on vsync and selects the front buffer, so the display never reads the buffer the frame drawer is writing.

---
 rtl/frame_fetcher.sv | 213 +++++++++++++++++++++
 tb/tb_frame_fetcher.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fetcher.sv
// rtl/frame_fetcher.sv - scanline fetcher from the SDRAM framebuffer into a two-bank line buffer
//
// Purpose: on each accepted line start, reads H_RES 32-bit words of one
// scanline from SDRAM. It issues one request at a time. The low 24 bits of
// each word go into bank line_y[0] of an on-chip line buffer. The display
// side reads 24-bit RGB by pixel coordinate with one cycle of latency.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   in_framebuffer_base     byte address of buffer 0 (0 = not ready)
//   in_fbuffer              buffer being drawn; the display uses the other
//   in_vsync                vsync level; its rising edge latches the frame base
//   in_line_start/in_line_y request a fetch of one scanline
//   in_pix_x/in_pix_y       display read coordinate
//   out_pix_rgb             registered pixel for the previous cycle's coordinate
//   out_sd_*                SDRAM user-port request (read only)
//   in_sd_data_out/in_sd_done SDRAM read data and completion pulse
//   out_busy                a line fetch is in progress
//   out_overrun             sticky: a line start arrived while busy
module frame_fetcher #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_framebuffer_base,
  input  logic        in_fbuffer,
  input  logic        in_vsync,
  input  logic        in_line_start,
  input  logic [8:0]  in_line_y,
  input  logic [9:0]  in_pix_x,
  input  logic [8:0]  in_pix_y,
  output logic [23:0] out_pix_rgb,
  output logic [31:0] out_sd_addr,
  output logic        out_sd_rw,
  output logic [31:0] out_sd_data_in,
  output logic        out_sd_in_valid,
  output logic [3:0]  out_sd_wmask,
  input  logic [31:0] in_sd_data_out,
  input  logic        in_sd_done,
  output logic        out_busy,
  output logic        out_overrun
);

  localparam logic [31:0] LINE_BYTES  = 32'(H_RES * 4);
  localparam logic [31:0] FRAME_BYTES = 32'(H_RES * V_RES * 4);
  localparam logic [9:0]  X_LAST      = 10'(H_RES - 1);
  localparam logic [10:0] BANK1_OFS   = 11'(H_RES);
  localparam int          DEPTH       = 2 * H_RES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        vsync_q, vsync_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic [31:0] frame_base_q, frame_base_d;
  logic        ready_q, ready_d;
  logic [31:0] addr_q, addr_d;
  logic [9:0]  x_q, x_d;
  logic        bank_q, bank_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        pend_bank_q, pend_bank_d;
  logic [23:0] pix_q, pix_d;

  logic [23:0] line_mem [DEPTH];

  logic        line_ok;
  logic [31:0] new_line_addr;
  logic        wr_en;
  logic [10:0] wr_idx;
  logic [10:0] rd_idx;
  logic        unused_bits;

  assign unused_bits = ^{in_sd_data_out[31:24], in_pix_y[8:1]};

  // A line start is only honoured for on-screen lines of a ready framebuffer.
  assign line_ok = in_line_start && ready_q && (in_line_y < 9'(V_RES));
  assign new_line_addr = frame_base_q + ({23'd0, in_line_y} * LINE_BYTES);

  assign wr_idx = {1'b0, x_q} + (bank_q ? BANK1_OFS : 11'd0);
  assign rd_idx = {1'b0, in_pix_x} + (in_pix_y[0] ? BANK1_OFS : 11'd0);

  always_comb begin
    state_d      = state_q;
    vsync_d      = in_vsync;
    vsync_prev_d = vsync_q;
    frame_base_d = frame_base_q;
    ready_d      = ready_q;
    addr_d       = addr_q;
    x_d          = x_q;
    bank_d       = bank_q;
    valid_d      = 1'b0;
    overrun_d    = overrun_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_bank_d  = pend_bank_q;
    wr_en        = 1'b0;
    pix_d        = 24'd0;

    // Front buffer is the one the drawer is not writing.
    if (vsync_q && !vsync_prev_q) begin
      frame_base_d = in_framebuffer_base + (in_fbuffer ? 32'd0 : FRAME_BYTES);
      ready_d      = (in_framebuffer_base != 32'd0);
    end

    // A line start while busy is queued (latest wins). Its address is
    // frozen now, so it uses the frame base that was current at the start.
    if (line_ok && (state_q != S_IDLE)) begin
      overrun_d   = 1'b1;
      pend_d      = 1'b1;
      pend_addr_d = new_line_addr;
      pend_bank_d = in_line_y[0];
    end

    case (state_q)
      S_IDLE: begin
        if (line_ok) begin
          addr_d  = new_line_addr;
          x_d     = 10'd0;
          bank_d  = in_line_y[0];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        valid_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (in_sd_done) begin
          wr_en = 1'b1;
          // pend_d also covers a line start arriving with this very done.
          if (pend_d) begin
            addr_d  = pend_addr_d;
            x_d     = 10'd0;
            bank_d  = pend_bank_d;
            pend_d  = 1'b0;
            state_d = S_REQ;
          end else if (x_q == X_LAST) begin
            state_d = S_IDLE;
          end else begin
            x_d     = x_q + 10'd1;
            addr_d  = addr_q + 32'd4;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ready_q && (in_pix_x < 10'(H_RES))) begin
      pix_d = line_mem[rd_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      frame_base_q <= 32'd0;
      ready_q      <= 1'b0;
      addr_q       <= 32'd0;
      x_q          <= 10'd0;
      bank_q       <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= 32'd0;
      pend_bank_q  <= 1'b0;
      pix_q        <= 24'd0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      vsync_prev_q <= vsync_prev_d;
      frame_base_q <= frame_base_d;
      ready_q      <= ready_d;
      addr_q       <= addr_d;
      x_q          <= x_d;
      bank_q       <= bank_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_bank_q  <= pend_bank_d;
      pix_q        <= pix_d;
    end
  end

  // Line buffer storage: no reset. The display read above sees the old
  // word when it hits the address being written in the same cycle.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      line_mem[wr_idx] <= in_sd_data_out[23:0];
    end
  end

  assign out_pix_rgb     = pix_q;
  assign out_sd_addr     = addr_q;
  assign out_sd_rw       = 1'b0;
  assign out_sd_data_in  = 32'd0;
  assign out_sd_in_valid = valid_q;
  assign out_sd_wmask    = 4'b0000;
  assign out_busy        = (state_q != S_IDLE);
  assign out_overrun     = overrun_q;

endmodule

// File: tb/tb_frame_fetcher.sv
// tb/tb_frame_fetcher.sv - self-checking bench for frame_fetcher
module tb_frame_fetcher;

  localparam int H = 640;
  localparam int V = 480;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_framebuffer_base;
  logic        in_fbuffer;
  logic        in_vsync;
  logic        in_line_start;
  logic [8:0]  in_line_y;
  logic [9:0]  in_pix_x;
  logic [8:0]  in_pix_y;
  logic [23:0] out_pix_rgb;
  logic [31:0] out_sd_addr;
  logic        out_sd_rw;
  logic [31:0] out_sd_data_in;
  logic        out_sd_in_valid;
  logic [3:0]  out_sd_wmask;
  logic [31:0] in_sd_data_out;
  logic        in_sd_done;
  logic        out_busy;
  logic        out_overrun;

  frame_fetcher #(.H_RES(H), .V_RES(V)) dut (
    .clock               (clock),
    .reset               (reset),
    .in_framebuffer_base (in_framebuffer_base),
    .in_fbuffer          (in_fbuffer),
    .in_vsync            (in_vsync),
    .in_line_start       (in_line_start),
    .in_line_y           (in_line_y),
    .in_pix_x            (in_pix_x),
    .in_pix_y            (in_pix_y),
    .out_pix_rgb         (out_pix_rgb),
    .out_sd_addr         (out_sd_addr),
    .out_sd_rw           (out_sd_rw),
    .out_sd_data_in      (out_sd_data_in),
    .out_sd_in_valid     (out_sd_in_valid),
    .out_sd_wmask        (out_sd_wmask),
    .in_sd_data_out      (in_sd_data_out),
    .in_sd_done          (in_sd_done),
    .out_busy            (out_busy),
    .out_overrun         (out_overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          bank;
    int          x;
    bit          wr;
  } req_t;

  req_t        exp_q[$];
  logic [23:0] model_buf [2][H];
  bit          model_ready;
  logic [31:0] model_base;

  int          n_pass;
  int          n_checks;
  int          req_seen;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          pend_bank;
  int          pend_x;
  bit          pend_wr;
  logic [31:0] last_req_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [23:0] model_pix(input int x, input int y);
    if (!model_ready || x >= H) return 24'd0;
    return model_buf[y % 2][x];
  endfunction

  // SDRAM model plus request checker: done three cycles after each request,
  // read data equals the requested address.
  initial begin
    req_t e;
    in_sd_done     = 1'b0;
    in_sd_data_out = 32'd0;
    forever begin
      @(negedge clock);
      if (in_sd_done) in_sd_done = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          in_sd_done     = 1'b1;
          in_sd_data_out = pend_addr;
          if (pend_wr) model_buf[pend_bank][pend_x] = pend_addr[23:0];
        end
      end
      if (out_sd_in_valid === 1'b1) begin
        req_seen++;
        last_req_addr = out_sd_addr;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_request actual addr=%h required=no request", out_sd_addr);
        end else begin
          e = exp_q.pop_front();
          chk("req_addr", out_sd_addr, e.addr);
          chk("req_ctrl", {27'd0, out_sd_rw, out_sd_wmask} | out_sd_data_in, 32'd0);
          pend_cnt  = 3;
          pend_addr = out_sd_addr;
          pend_bank = e.bank;
          pend_x    = e.x;
          pend_wr   = e.wr;
        end
      end
    end
  end

  task automatic push_line(input int y, input int first, input int last, input bit wr);
    req_t e;
    for (int i = first; i <= last; i++) begin
      e.addr = model_base + 32'(y * H * 4) + 32'(i * 4);
      e.bank = y % 2;
      e.x    = i;
      e.wr   = wr;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_vsync(input logic [31:0] base, input bit fb);
    @(posedge clock); #1;
    in_framebuffer_base = base;
    in_fbuffer          = fb;
    in_vsync            = 1'b1;
    repeat (3) @(posedge clock);
    #1 in_vsync = 1'b0;
    repeat (2) @(posedge clock);
    model_ready = (base != 32'd0);
    model_base  = base + (fb ? 32'd0 : 32'(H * V * 4));
  endtask

  task automatic line_start(input int y);
    @(posedge clock); #1;
    in_line_start = 1'b1;
    in_line_y     = 9'(y);
    @(posedge clock); #1;
    in_line_start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && pend_cnt == 0 && !in_sd_done && out_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_complete"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_reqs(input int target, input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (req_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_reached"}, 32'(ok), 32'd1);
  endtask

  task automatic read_pix(input int x, input int y, output logic [23:0] v);
    @(posedge clock); #1;
    in_pix_x = 10'(x);
    in_pix_y = 9'(y);
    @(posedge clock);
    @(negedge clock);
    v = out_pix_rgb;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, out_sd_addr, 32'd0);
    chk({tag, "_valid"}, 32'(out_sd_in_valid), 32'd0);
    chk({tag, "_busy"}, 32'(out_busy), 32'd0);
    chk({tag, "_overrun"}, 32'(out_overrun), 32'd0);
    chk({tag, "_pix"}, 32'(out_pix_rgb), 32'd0);
    chk({tag, "_ctrl"}, {27'd0, out_sd_rw, out_sd_wmask} | out_sd_data_in, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] v;
    int start;
    n_pass = 0; n_checks = 0; req_seen = 0; pend_cnt = 0;
    model_ready = 1'b0; model_base = 32'd0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < H; i++) model_buf[b][i] = 24'd0;
    in_framebuffer_base = 32'd0;
    in_fbuffer = 1'b0;
    in_vsync = 1'b0;
    in_line_start = 1'b0;
    in_line_y = 9'd0;
    in_pix_x = 10'd0;
    in_pix_y = 9'd0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock); #1 reset = 1'b0;

    // Full line 0 from buffer 0 at 0x100000.
    do_vsync(32'h0010_0000, 1'b1);
    push_line(0, 0, H - 1, 1'b1);
    start = req_seen;
    line_start(0);
    @(negedge clock);
    chk("start_busy", 32'(out_busy), 32'd1);
    chk("start_valid_early", 32'(out_sd_in_valid), 32'd0);
    @(negedge clock);
    chk("start_valid_latency", 32'(out_sd_in_valid), 32'd1);
    wait_idle(5000, "line0");
    chk("line0_req_count", 32'(req_seen - start), 32'd640);
    read_pix(5, 0, v);
    chk("pix_5_0_literal", 32'(v), 32'h0010_0014);
    read_pix(639, 0, v);
    chk("pix_639_0_literal", 32'(v), 32'h0010_09FC);
    chk("pix_639_0_model", 32'(v), 32'(model_pix(639, 0)));

    // Other buffer selected, line 2.
    do_vsync(32'h0010_0000, 1'b0);
    push_line(2, 0, H - 1, 1'b1);
    start = req_seen;
    line_start(2);
    wait_reqs(start + 1, 20, "line2_first");
    chk("line2_first_addr", last_req_addr, 32'h0022_D400);
    wait_idle(5000, "line2");

    // Overrun: line 7 arrives while line 6 waits on word 100.
    push_line(6, 0, 100, 1'b1);
    start = req_seen;
    line_start(6);
    wait_reqs(start + 101, 2000, "line6_word100");
    push_line(7, 0, H - 1, 1'b1);
    line_start(7);
    @(negedge clock);
    chk("overrun_set", 32'(out_overrun), 32'd1);
    wait_idle(5000, "line7");
    chk("overrun_req_count", 32'(req_seen - start), 32'd741);
    read_pix(0, 0, v);
    chk("l6_w0_literal", 32'(v), 32'h0022_FC00);
    read_pix(99, 0, v);
    chk("l6_w99_literal", 32'(v), 32'h0022_FD8C);
    read_pix(100, 0, v);
    chk("l6_w100_model", 32'(v), 32'(model_pix(100, 0)));
    read_pix(101, 0, v);
    chk("l2_w101_literal", 32'(v), 32'h0022_D594);
    read_pix(0, 1, v);
    chk("l7_w0_literal", 32'(v), 32'h0023_0600);
    read_pix(639, 1, v);
    chk("l7_w639_model", 32'(v), 32'(model_pix(639, 1)));

    // Framebuffer not ready.
    do_vsync(32'd0, 1'b1);
    start = req_seen;
    line_start(3);
    repeat (50) @(negedge clock);
    chk("notready_no_req", 32'(req_seen - start), 32'd0);
    chk("notready_busy", 32'(out_busy), 32'd0);
    read_pix(5, 0, v);
    chk("notready_pix", 32'(v), 32'(model_pix(5, 0)));
    chk("overrun_sticky", 32'(out_overrun), 32'd1);

    // Off-screen line and off-screen column.
    do_vsync(32'h0010_0000, 1'b1);
    start = req_seen;
    line_start(480);
    repeat (20) @(negedge clock);
    chk("y480_no_req", 32'(req_seen - start), 32'd0);
    chk("y480_busy", 32'(out_busy), 32'd0);
    read_pix(700, 0, v);
    chk("x700_pix", 32'(v), 32'd0);
    read_pix(5, 0, v);
    chk("pix_5_0_model", 32'(v), 32'(model_pix(5, 0)));
    read_pix(600, 0, v);
    chk("pix_600_0_model", 32'(v), 32'(model_pix(600, 0)));

    // Reset while waiting on SDRAM; the late done must not write bank 1.
    push_line(1, 0, 0, 1'b0);
    start = req_seen;
    line_start(1);
    wait_reqs(start + 1, 20, "reset_req");
    chk("reset_req_addr", last_req_addr, 32'h0010_0A00);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("midreset");
    @(posedge clock); #1 reset = 1'b0;
    repeat (8) @(negedge clock);
    chk("postreset_busy", 32'(out_busy), 32'd0);
    chk("postreset_no_req", 32'(req_seen - start), 32'd1);
    chk("postreset_addr", out_sd_addr, 32'd0);
    do_vsync(32'h0010_0000, 1'b1);
    read_pix(0, 1, v);
    chk("postreset_bank1_literal", 32'(v), 32'h0023_0600);
    chk("postreset_bank1_model", 32'(v), 32'(model_pix(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
